// File: rtl/grn_cycle_ctrl_if.sv
// Bundles the host handshake and node-array strobe/readback signals of grn_cycle_ctrl.
// The controller takes the slave view; the host/node side takes the master view.
interface grn_cycle_ctrl_if #(
  parameter int N_NODES = 8,
  parameter int CNT_W   = 16
);
  logic               start;
  logic               abort;
  logic [N_NODES-1:0] init_vec;
  logic [N_NODES-1:0] s0_vec;
  logic [N_NODES-1:0] s1_vec;
  logic               reset_nos;
  logic [N_NODES-1:0] node_init;
  logic               start_s0;
  logic               start_s1;
  logic               busy;
  logic               done;
  logic               timeout;
  logic               aborted;
  logic [CNT_W-1:0]   steps;
  logic [N_NODES-1:0] met_vec;

  modport slave (
    input  start, abort, init_vec, s0_vec, s1_vec,
    output reset_nos, node_init, start_s0, start_s1,
           busy, done, timeout, aborted, steps, met_vec
  );

  modport master (
    output start, abort, init_vec, s0_vec, s1_vec,
    input  reset_nos, node_init, start_s0, start_s1,
           busy, done, timeout, aborted, steps, met_vec
  );
endinterface

// File: rtl/grn_cycle_ctrl.sv
// Tortoise/hare run controller for the Boolean-network node array: loads the nodes,
// steps slow and fast copies together and reports the step count at which they meet.
//
// state | meaning
// IDLE  | waiting for start; results held
// LOAD  | reset_nos strobe, nodes load node_init
// STEP  | start_s0/start_s1 strobe, step counter advances
// CHECK | node outputs settled; compare copies / check budget
// DONE  | one-cycle done pulse, results valid
module grn_cycle_ctrl #(
  parameter int N_NODES   = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 1000  // even, below 2**CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  grn_cycle_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    STEP  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] MIN_CMP = CNT_W'(2);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_NODES-1:0] r_node_init;
  logic               r_timeout;
  logic               r_aborted;
  logic [CNT_W-1:0]   r_steps;
  logic [N_NODES-1:0] r_met_vec;

  logic w_busy;
  logic w_meet;

  assign w_busy = (r_state == LOAD) || (r_state == STEP) || (r_state == CHECK);
  // Odd counts are skipped: after an odd number of steps the copies are not a valid pair.
  assign w_meet = !r_cnt[0] && (r_cnt >= MIN_CMP) && (bus.s0_vec == bus.s1_vec);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_node_init <= '0;
      r_timeout   <= 1'b0;
      r_aborted   <= 1'b0;
      r_steps     <= '0;
      r_met_vec   <= '0;
    end else if (w_busy && bus.abort) begin
      r_aborted <= 1'b1;
      r_steps   <= r_cnt;
      r_met_vec <= bus.s1_vec;
      r_state   <= DONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_node_init <= bus.init_vec;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
            r_aborted   <= 1'b0;
            r_steps     <= '0;
            r_met_vec   <= '0;
            r_state     <= LOAD;
          end
        end
        LOAD: r_state <= STEP;
        STEP: begin
          r_cnt   <= r_cnt + 1'b1;
          r_state <= CHECK;
        end
        CHECK: begin
          if (w_meet) begin
            r_steps   <= r_cnt;
            r_met_vec <= bus.s1_vec;
            r_state   <= DONE;
          end else if (r_cnt == MAX_CNT) begin
            r_timeout <= 1'b1;
            r_steps   <= r_cnt;
            r_met_vec <= bus.s1_vec;
            r_state   <= DONE;
          end else begin
            r_state <= STEP;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Abort in LOAD/STEP suppresses that cycle's strobe so the nodes never see a half-run step.
  assign bus.reset_nos = (r_state == LOAD) && !bus.abort;
  assign bus.start_s0  = (r_state == STEP) && !bus.abort;
  assign bus.start_s1  = (r_state == STEP) && !bus.abort;
  assign bus.busy      = w_busy;
  assign bus.done      = (r_state == DONE);
  assign bus.node_init = r_node_init;
  assign bus.timeout   = r_timeout;
  assign bus.aborted   = r_aborted;
  assign bus.steps     = r_steps;
  assign bus.met_vec   = r_met_vec;

endmodule

// File: tb/tb_grn_cycle_ctrl.sv
// Directed bench for grn_cycle_ctrl: behavioural node-array models feed s0/s1 back,
// per-cycle traces are compared against hand-derived cycle masks and result values.
module tb_grn_cycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  grn_cycle_ctrl_if #(.N_NODES(8), .CNT_W(16)) bus ();
  grn_cycle_ctrl_if #(.N_NODES(8), .CNT_W(16)) bus4 ();

  grn_cycle_ctrl #(.N_NODES(8), .CNT_W(16), .MAX_STEPS(1000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  grn_cycle_ctrl #(.N_NODES(8), .CNT_W(16), .MAX_STEPS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4));

  logic       start0, abort0, start4;
  logic [7:0] init_vec;
  int         mode0, mode4;
  logic [7:0] m0_slow = '0, m0_fast = '0, m4_slow = '0, m4_fast = '0;
  logic       m0_pass = 1'b0, m4_pass = 1'b0;

  assign bus.start     = start0;
  assign bus.abort     = abort0;
  assign bus.init_vec  = init_vec;
  assign bus.s0_vec    = m0_slow;
  assign bus.s1_vec    = m0_fast;
  assign bus4.start    = start4;
  assign bus4.abort    = 1'b0;
  assign bus4.init_vec = init_vec;
  assign bus4.s0_vec   = m4_slow;
  assign bus4.s1_vec   = m4_fast;

  // mode 0: identity, 1: ring counter period 3, 2: ring counter period 7
  function automatic logic [7:0] f_next(input int mode, input logic [7:0] x);
    case (mode)
      1:       return (x >= 8'd2) ? 8'd0 : x + 8'd1;
      2:       return (x >= 8'd6) ? 8'd0 : x + 8'd1;
      default: return x;
    endcase
  endfunction

  // Node array: fast copy steps on every strobe, slow copy on the 1st, 3rd, 5th ...
  always @(posedge clk) begin
    if (bus.reset_nos) begin
      m0_slow <= bus.node_init; m0_fast <= bus.node_init; m0_pass <= 1'b0;
    end else begin
      if (bus.start_s1) m0_fast <= f_next(mode0, m0_fast);
      if (bus.start_s0) begin
        if (!m0_pass) m0_slow <= f_next(mode0, m0_slow);
        m0_pass <= ~m0_pass;
      end
    end
  end

  always @(posedge clk) begin
    if (bus4.reset_nos) begin
      m4_slow <= bus4.node_init; m4_fast <= bus4.node_init; m4_pass <= 1'b0;
    end else begin
      if (bus4.start_s1) m4_fast <= f_next(mode4, m4_fast);
      if (bus4.start_s0) begin
        if (!m4_pass) m4_slow <= f_next(mode4, m4_slow);
        m4_pass <= ~m4_pass;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] tr_rn, tr_s0, tr_s1, tr_done, tr_busy;
  logic [7:0]  tr_ninit [0:63];

  // Cycle 0 is the cycle in which start is high and sampled.
  task automatic launch(input int sel, input logic [7:0] iv);
    @(posedge clk); #1;
    init_vec = iv;
    if (sel == 0) start0 = 1'b1; else start4 = 1'b1;
    #1;
  endtask

  // Records cycles 1..n; start stays high through start_until, abort pulses in abort_at.
  task automatic capture(input int sel, input int n, input int start_until,
                         input int abort_at, input logic [7:0] iv_late);
    tr_rn = '0; tr_s0 = '0; tr_s1 = '0; tr_done = '0; tr_busy = '0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (sel == 0) start0 = (c <= start_until); else start4 = (c <= start_until);
      abort0 = (c == abort_at);
      if (c == 2) init_vec = iv_late;
      #1;
      if (sel == 0) begin
        tr_rn[c] = bus.reset_nos; tr_s0[c] = bus.start_s0; tr_s1[c] = bus.start_s1;
        tr_done[c] = bus.done; tr_busy[c] = bus.busy; tr_ninit[c] = bus.node_init;
      end else begin
        tr_rn[c] = bus4.reset_nos; tr_s0[c] = bus4.start_s0; tr_s1[c] = bus4.start_s1;
        tr_done[c] = bus4.done; tr_busy[c] = bus4.busy; tr_ninit[c] = bus4.node_init;
      end
    end
    abort0 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start0 = 1'b0; start4 = 1'b0; abort0 = 1'b0; init_vec = 8'h00;
    mode0 = 0; mode4 = 0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({bus.reset_nos, bus.start_s0, bus.start_s1, bus.busy, bus.done, bus.timeout, bus.aborted} !== 7'b0)
      $display("FAIL reset_flags: got %b want 0000000",
               {bus.reset_nos, bus.start_s0, bus.start_s1, bus.busy, bus.done, bus.timeout, bus.aborted});
    else n_pass++;
    n_checks++;
    if ({bus.steps, bus.met_vec, bus.node_init} !== 32'h0)
      $display("FAIL reset_results: got steps=%0d met=%h init=%h want 0/00/00",
               bus.steps, bus.met_vec, bus.node_init);
    else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #2;
    n_checks++;
    if ({bus.busy, bus.start_s0, bus4.busy, bus4.start_s0} !== 4'b0)
      $display("FAIL reset_release_idle: got %b want 0000",
               {bus.busy, bus.start_s0, bus4.busy, bus4.start_s0});
    else n_pass++;
  endtask

  task automatic test_identity();
    mode0 = 0;
    launch(0, 8'hA5);
    capture(0, 6, 0, 0, 8'hA5);
    n_checks++;
    if (tr_rn !== 64'h2 || tr_ninit[1] !== 8'hA5)
      $display("FAIL ident_load: got rn=%h init=%h want rn=2 init=a5", tr_rn, tr_ninit[1]);
    else n_pass++;
    n_checks++;
    if (tr_s0 !== 64'h14 || tr_s1 !== 64'h14)
      $display("FAIL ident_strobes: got s0=%h s1=%h want 14/14", tr_s0, tr_s1);
    else n_pass++;
    n_checks++;
    if (tr_done !== 64'h40 || tr_busy !== 64'h3E)
      $display("FAIL ident_done_busy: got done=%h busy=%h want 40/3e", tr_done, tr_busy);
    else n_pass++;
    n_checks++;
    if (bus.steps !== 16'd2 || bus.met_vec !== 8'hA5 || bus.timeout !== 1'b0 || bus.aborted !== 1'b0)
      $display("FAIL ident_result: got steps=%0d met=%h to=%b ab=%b want 2/a5/0/0",
               bus.steps, bus.met_vec, bus.timeout, bus.aborted);
    else n_pass++;
  endtask

  task automatic test_ring3();
    mode0 = 1;
    launch(0, 8'h00);
    capture(0, 14, 0, 0, 8'h00);
    n_checks++;
    if (tr_done !== 64'h4000 || tr_busy !== 64'h3FFE)
      $display("FAIL ring3_done: got done=%h busy=%h want 4000/3ffe", tr_done, tr_busy);
    else n_pass++;
    n_checks++;
    if (tr_s0 !== 64'h1554 || tr_s1 !== 64'h1554)
      $display("FAIL ring3_strobes: got s0=%h s1=%h want 1554/1554", tr_s0, tr_s1);
    else n_pass++;
    n_checks++;
    if (bus.steps !== 16'd6 || bus.met_vec !== 8'h00 || bus.timeout !== 1'b0)
      $display("FAIL ring3_result: got steps=%0d met=%h to=%b want 6/00/0",
               bus.steps, bus.met_vec, bus.timeout);
    else n_pass++;
  endtask

  task automatic test_timeout();
    mode4 = 2;
    launch(1, 8'h00);
    capture(1, 10, 0, 0, 8'h00);
    n_checks++;
    if (tr_done !== 64'h400)
      $display("FAIL tmo_done_cycle: got done=%h want 400", tr_done);
    else n_pass++;
    n_checks++;
    if ($countones(tr_s0) != 4 || $countones(tr_s1) != 4 || tr_s0 !== 64'h154)
      $display("FAIL tmo_strobe_count: got s0=%h s1=%h want 154/154", tr_s0, tr_s1);
    else n_pass++;
    n_checks++;
    if (bus4.timeout !== 1'b1 || bus4.steps !== 16'd4 || bus4.met_vec !== 8'h04 || bus4.aborted !== 1'b0)
      $display("FAIL tmo_result: got to=%b steps=%0d met=%h ab=%b want 1/4/04/0",
               bus4.timeout, bus4.steps, bus4.met_vec, bus4.aborted);
    else n_pass++;
  endtask

  task automatic test_abort();
    mode0 = 2;
    launch(0, 8'h00);
    capture(0, 7, 0, 6, 8'h00);
    n_checks++;
    if (tr_s0 !== 64'h14 || tr_s1 !== 64'h14 || tr_rn !== 64'h2)
      $display("FAIL abort_strobes: got s0=%h s1=%h rn=%h want 14/14/2", tr_s0, tr_s1, tr_rn);
    else n_pass++;
    n_checks++;
    if (tr_done !== 64'h80 || tr_busy !== 64'h7E)
      $display("FAIL abort_done: got done=%h busy=%h want 80/7e", tr_done, tr_busy);
    else n_pass++;
    n_checks++;
    if (bus.aborted !== 1'b1 || bus.steps !== 16'd2 || bus.met_vec !== 8'h02 || bus.timeout !== 1'b0)
      $display("FAIL abort_result: got ab=%b steps=%0d met=%h to=%b want 1/2/02/0",
               bus.aborted, bus.steps, bus.met_vec, bus.timeout);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    mode0 = 2;
    launch(0, 8'h11);
    capture(0, 2, 0, 0, 8'h11);
    @(posedge clk); #1; rst_n = 1'b0; #1;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.start_s0 !== 1'b0)
      $display("FAIL rstmid_in_check: got busy=%b s0=%b want 1/0", bus.busy, bus.start_s0);
    else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1; #1;
    n_checks++;
    if ({bus.reset_nos, bus.start_s0, bus.start_s1, bus.busy, bus.done, bus.timeout, bus.aborted} !== 7'b0
        || {bus.steps, bus.met_vec, bus.node_init} !== 32'h0)
      $display("FAIL rstmid_outputs: got flags=%b steps=%0d met=%h init=%h want 0/0/00/00",
               {bus.reset_nos, bus.start_s0, bus.start_s1, bus.busy, bus.done, bus.timeout, bus.aborted},
               bus.steps, bus.met_vec, bus.node_init);
    else n_pass++;
    mode0 = 0;
    launch(0, 8'h5A);
    capture(0, 6, 0, 0, 8'h5A);
    n_checks++;
    if (tr_rn !== 64'h2 || tr_done !== 64'h40 || bus.steps !== 16'd2 || bus.met_vec !== 8'h5A)
      $display("FAIL rstmid_rerun: got rn=%h done=%h steps=%0d met=%h want 2/40/2/5a",
               tr_rn, tr_done, bus.steps, bus.met_vec);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    mode0 = 0;
    launch(0, 8'hA5);
    capture(0, 13, 13, 0, 8'h3C);
    @(posedge clk); #1; start0 = 1'b0;
    n_checks++;
    if (tr_rn !== 64'h102 || tr_done !== 64'h2040 || tr_busy !== 64'h1F3E)
      $display("FAIL b2b_timing: got rn=%h done=%h busy=%h want 102/2040/1f3e",
               tr_rn, tr_done, tr_busy);
    else n_pass++;
    n_checks++;
    if (tr_ninit[7] !== 8'hA5 || tr_ninit[8] !== 8'h3C)
      $display("FAIL b2b_recapture: got c7=%h c8=%h want a5/3c", tr_ninit[7], tr_ninit[8]);
    else n_pass++;
    n_checks++;
    if (bus.steps !== 16'd2 || bus.met_vec !== 8'h3C)
      $display("FAIL b2b_result: got steps=%0d met=%h want 2/3c", bus.steps, bus.met_vec);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_ring3();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
